// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Purpose  : Walks every register-file address, streams (addr, data) words out
//            over valid/ready and accumulates an XOR parity of the dump.
// Revision : 1.0
// ============================================================================
module regfile_dump #(
    parameter int ADDR_W   = 1,
    parameter int DATA_W   = 1,
    parameter int READ_LAT = 0
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] parity_o,
    output logic [ADDR_W-1:0] readReg_o,
    input  logic [DATA_W-1:0] readData_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o
);
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] parity_q, parity_d;
    logic              w_capture;
    logic              w_addr_capture;

    // A combinational register file delivers data in ADDR; a registered one a cycle later.
    if (READ_LAT == 0) begin : g_comb_read
        assign w_addr_capture = 1'b1;
    end else begin : g_reg_read
        assign w_addr_capture = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            parity_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        parity_d  = parity_q;
        w_capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_ADDR;
                    addr_d   = '0;
                    parity_d = '0;
                end
            end
            S_ADDR: begin
                w_capture = w_addr_capture;
                state_d   = w_addr_capture ? S_SEND : S_WAIT;
            end
            S_WAIT: begin
                w_capture = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (out_ready_i) begin
                    if (addr_q == C_LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (w_capture) begin
            data_d   = readData_i;
            parity_d = parity_q ^ readData_i;
        end
    end

    // The counter is left at the last address after a dump, so IDLE forces the read port to 0.
    assign readReg_o   = (state_q == S_IDLE) ? '0 : addr_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign out_valid_o = (state_q == S_SEND);
    assign out_last_o  = (state_q == S_SEND) && (addr_q == C_LAST_ADDR);
    assign out_addr_o  = addr_q;
    assign out_data_o  = data_q;
    assign parity_o    = parity_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump
// Purpose  : Self-checking bench for regfile_dump over three configurations.
// Revision : 1.0
// ============================================================================
module tb_regfile_dump;
    localparam int N_CFG = 3;
    localparam int CFG_AW [N_CFG] = '{1, 1, 2};
    localparam int CFG_DW [N_CFG] = '{1, 1, 4};
    localparam int CFG_RL [N_CFG] = '{0, 1, 0};
    localparam int CFG_INIT [N_CFG][4] = '{'{1, 0, 0, 0}, '{1, 1, 0, 0}, '{3, 5, 9, 15}};
    localparam int N_RAND = 6;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_fin = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < N_CFG; g++) begin : g_cfg
        localparam int A    = CFG_AW[g];
        localparam int D    = CFG_DW[g];
        localparam int RL   = CFG_RL[g];
        localparam int NR   = 1 << A;
        localparam int COST = RL + 2;

        logic         reset, start, busy, done, out_valid, out_ready, out_last;
        logic [D-1:0] parity, rdata, out_data;
        logic [A-1:0] raddr, out_addr;
        logic [D-1:0] mem [NR];
        int           q_addr [$];
        int           q_data [$];
        int           q_last [$];
        int           n_done  = 0;
        int           first_v = -1;
        int           done_c  = -1;

        if (RL == 0) begin : g_comb_rf
            assign rdata = mem[raddr];
        end else begin : g_reg_rf
            always @(posedge clk) rdata <= mem[raddr];
        end

        regfile_dump #(.ADDR_W(A), .DATA_W(D), .READ_LAT(RL)) u_dut (
            .clk_i       (clk),
            .reset_i     (reset),
            .start_i     (start),
            .busy_o      (busy),
            .done_o      (done),
            .parity_o    (parity),
            .readReg_o   (raddr),
            .readData_i  (rdata),
            .out_valid_o (out_valid),
            .out_ready_i (out_ready),
            .out_addr_o  (out_addr),
            .out_data_o  (out_data),
            .out_last_o  (out_last)
        );

        task automatic ck(input string t, input longint o, input longint e);
            chk($sformatf("c%0d_%s", g, t), o, e);
        endtask

        function automatic int exp_parity();
            int p = 0;
            for (int i = 0; i < NR; i++) p ^= int'(mem[i]);
            return p;
        endfunction

        // Every presented word must be the next address in order with that address's contents.
        initial begin : mon
            int idx;
            forever begin
                @(negedge clk);
                if (out_valid) begin
                    idx = q_addr.size();
                    ck("vaddr", out_addr, idx);
                    if (idx < NR) ck("vdata", out_data, mem[idx]);
                    ck("vlast", out_last, idx == NR - 1);
                    if (first_v < 0) first_v = cyc;
                    if (out_ready) begin
                        q_addr.push_back(int'(out_addr));
                        q_data.push_back(int'(out_data));
                        q_last.push_back(int'(out_last));
                    end
                end
                if (done) begin
                    n_done++;
                    done_c = cyc;
                end
            end
        end

        task automatic clear_mon();
            q_addr.delete();
            q_data.delete();
            q_last.delete();
            n_done  = 0;
            first_v = -1;
            done_c  = -1;
        endtask

        task automatic run_dump(input bit rnd, input bit stall, input bit dup);
            int s;
            int guard = 0;
            clear_mon();
            out_ready = !stall;
            start = 1'b1;
            s = cyc;
            tick();
            start = 1'b0;
            if (stall) begin
                while (!out_valid && guard < 20) begin
                    tick();
                    guard++;
                end
                if (dup) start = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    ck("bp_valid", out_valid, 1);
                    ck("bp_addr", out_addr, 0);
                    ck("bp_data", out_data, mem[0]);
                    tick();
                    start = 1'b0;
                end
                out_ready = 1'b1;
            end
            while (n_done == 0 && guard < 400) begin
                if (rnd) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    start     = busy && ($urandom_range(0, 5) == 0);
                end
                tick();
                guard++;
            end
            start = 1'b0;
            ck("ndone", n_done, 1);
            ck("nwords", q_addr.size(), NR);
            for (int i = 0; i < NR && i < q_addr.size(); i++) begin
                ck("waddr", q_addr[i], i);
                ck("wdata", q_data[i], mem[i]);
                ck("wlast", q_last[i], i == NR - 1);
            end
            ck("parity", parity, exp_parity());
            if (!rnd) begin
                ck("lat_first", first_v - s, COST);
                ck("lat_done", done_c - s, NR * COST + 1 + (stall ? 4 : 0));
            end
            repeat (3) tick();
            ck("idle_busy", busy, 0);
            ck("post_ndone", n_done, 1);
            ck("post_nwords", q_addr.size(), NR);
            ck("parity_hold", parity, exp_parity());
        endtask

        task automatic reset_mid();
            int guard = 0;
            clear_mon();
            out_ready = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            while (q_addr.size() == 0 && guard < 20) begin
                tick();
                guard++;
            end
            ck("rst_busy_before", busy, 1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            ck("rst_outs", {busy, done, parity, raddr, out_valid, out_addr, out_data, out_last}, 0);
            repeat (8) tick();
            ck("rst_nodone", n_done, 0);
            ck("rst_nowords", q_addr.size(), 1);
            ck("rst_idle", busy, 0);
        endtask

        initial begin : drv
            reset     = 1'b1;
            start     = 1'b0;
            out_ready = 1'b0;
            for (int i = 0; i < NR; i++) mem[i] = D'(CFG_INIT[g][i]);
            repeat (3) tick();
            ck("reset_outs", {busy, done, parity, raddr, out_valid, out_addr, out_data, out_last}, 0);
            reset = 1'b0;
            tick();
            ck("idle_raddr", raddr, 0);
            run_dump(1'b0, 1'b0, 1'b0);
            run_dump(1'b0, 1'b1, 1'b0);
            run_dump(1'b0, 1'b1, 1'b1);
            reset_mid();
            run_dump(1'b0, 1'b0, 1'b0);
            for (int r = 0; r < N_RAND; r++) begin
                for (int i = 0; i < NR; i++) mem[i] = D'($urandom);
                run_dump(1'b1, 1'b0, 1'b0);
            end
            n_fin++;
        end
    end

    initial begin : summary
        fork
            wait (n_fin == N_CFG);
            #200000;
        join_any
        if (n_fin != N_CFG) chk("global_timeout", n_fin, N_CFG);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_dump.md
# regfile_dump

Read-side sequencer for `regfile_impl`: on a start pulse it walks every register address through the register file's read port, captures each value and streams it out as (address, data) words over a valid/ready handshake. It also accumulates an XOR parity of all dumped data. It sits beside the register file as its readback/debug port, the reader that pairs with the existing write-side stimulus.

## Interface
- `ADDR_W`, 1, register address width; the block dumps `NUM_REGS = 2**ADDR_W` entries.
- `DATA_W`, 1, register data width.
- `READ_LAT`, 0, register-file read latency in cycles; legal values are 0 (combinational read) and 1 (registered read).

- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse when the last word has been accepted.
- `parity`  out  DATA_W  XOR of all data words in the current or last dump.
- `readReg`  out  ADDR_W  address driven to the register file read port.
- `readData`  in  DATA_W  register file read data.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_addr`  out  ADDR_W  address of the current output word.
- `out_data`  out  DATA_W  data of the current output word.
- `out_last`  out  1  high with `out_valid` on the final address (`NUM_REGS-1`).

## Operation
- **States:** IDLE, ADDR, WAIT (exists only when `READ_LAT=1`), SEND, DONE.
- **IDLE:** `busy=0`, `readReg` holds 0.
  - `start=1` → ADDR. Address counter ← 0, `parity` ← 0.
- **ADDR:** `readReg` = address counter.
  - `READ_LAT=0`: capture `readData` into `out_data` and fold it into `parity` (XOR), then → SEND.
  - `READ_LAT=1`: → WAIT.
- **WAIT:** `readReg` unchanged. Capture `readData` into `out_data` and fold it into `parity`, then → SEND.
- **SEND:** `out_valid=1`; `out_addr`, `out_data` and `out_last` are held stable until the handshake completes.
  - On `out_valid && out_ready`:
    - If the address is `NUM_REGS-1` → DONE.
    - Otherwise the address counter increments and → ADDR.
- **DONE:** `done=1` and `busy=1` for exactly one cycle, then → IDLE. `parity` holds its value until the next accepted `start`.
- **Address counter:** ADDR_W bits. It never wraps during a dump because termination occurs at `NUM_REGS-1`.
- **Parity:** bitwise XOR over DATA_W; no carry and no width growth.
- **`start` handling:** ignored in every state except IDLE. No queuing; a `start` while busy is dropped.
- **`out_ready` handling:** ignored outside SEND. `out_valid` never depends combinationally on `out_ready`.
- **Write port:** the block never drives the register file write port. Writes that land during a dump are visible only for addresses not yet read.

## Timing
- **Reset values** (`reset=1` at an edge): state=IDLE, `busy=0`, `done=0`, `parity=0`, `readReg=0`, `out_valid=0`, `out_addr=0`, `out_data=0`, `out_last=0`, address counter=0.
- **Reset mid-dump:** the dump is aborted at that edge, with no `done` pulse and no further `out_valid`. `reset` has priority over `start` in the same cycle.
- **Latency, `start` to first `out_valid`:**
  - 2 cycles when `READ_LAT=0` (IDLE→ADDR→SEND).
  - 3 cycles when `READ_LAT=1`.
- **Per-word cost with `out_ready` held high:**
  - 2 cycles (`READ_LAT=0`) or 3 cycles (`READ_LAT=1`).
  - Full dump = `NUM_REGS`×(that count) + 1 (DONE) cycles after `start`.
- **Back-pressure:** with `out_ready=0` the block holds SEND indefinitely and outputs stay constant.
- **`done` pulse:** asserted in the cycle after the last handshake. `parity` is final and stable from that cycle onward.
- **Back-to-back dumps:** a `start` in the cycle after DONE (IDLE) is accepted normally.

## Test plan
- **Basic dump** (defaults, `out_ready=1`). Write reg0=1 and reg1=0 through the regfile, then pulse `start`. Required:
  - Words (addr 0, data 1, last 0) then (1, 0, 1).
  - `done` pulses 5 cycles after `start`.
  - `parity=1`.
- **Back-pressure.** Same contents with `out_ready=0` for 4 cycles in SEND. Required:
  - `out_valid`, `out_addr=0` and `out_data=1` stay stable for all 4 cycles.
  - Exactly one transfer of word 0 when `out_ready` rises.
  - No duplicate or skipped word.
- **`READ_LAT=1`**, registered-read regfile model, reg0=1, reg1=1. Required:
  - First `out_valid` 3 cycles after `start`.
  - Data 1, 1.
  - `parity=0`.
  - `done` 7 cycles after `start`.
- **`start` while busy.** Pulse `start` again during word 0's SEND. Required:
  - Exactly 2 words are emitted.
  - One `done` pulse.
  - No restart.
- **Reset mid-dump.** Assert `reset` during word 1's ADDR. Required:
  - Next cycle: all outputs 0 and `busy=0`.
  - No `done` pulse.
  - A subsequent `start` dumps from address 0.
- **Wider config** (`ADDR_W=2`, `DATA_W=4`, regs 0x3, 0x5, 0x9, 0xF). Required:
  - 4 words in address order, with `out_last` only on addr 3.
  - `parity=0x0`.
